mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/load-store) arbiter in front of a single-port word memory
//
// Shares one single-port word memory (1-cycle registered read, byte write
// strobes) between the instruction-fetch port (i_*) and the load/store port
// (d_*). At most one request is accepted per cycle; its response returns to
// the owning port exactly one cycle later, with no response backpressure.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   i_req_valid/addr/ready        fetch request (read only, byte address)
//   i_flush                       drop the in-flight and same-cycle fetch response
//   i_rsp_valid/rdata/err         fetch response
//   d_req_valid/addr/wdata/wstrb  load/store request (wstrb == 0 means load)
//   d_req_ready                   load/store accepted this cycle
//   d_rsp_valid/rdata/err         load/store response
//   mem_en/addr/wdata/wen         memory command
//   mem_rdata, mem_rvld           memory read return

module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_req_valid,
    input  logic [31:0]           i_req_addr,
    output logic                  i_req_ready,
    input  logic                  i_flush,
    output logic                  i_rsp_valid,
    output logic [DATA_WIDTH-1:0] i_rsp_rdata,
    output logic                  i_rsp_err,
    input  logic                  d_req_valid,
    input  logic [31:0]           d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    input  logic [STRB_WIDTH-1:0] d_req_wstrb,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_rdata,
    output logic                  d_rsp_err,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvld
);

    localparam int ADDR_HI = ADDR_WIDTH + 2;

    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

    state_e state;
    state_e state_next;
    port_e  rr;
    port_e  trk_owner;
    logic   trk_is_read;
    logic   trk_err;
    logic   trk_flushed;

    logic i_in_range;
    logic d_in_range;
    logic grant_i;
    logic grant_d;
    logic any_grant;
    logic pend;
    logic i_suppress;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // Byte-offset bits are ignored: the LSU pre-aligns data and strobes.
    logic unused_ok;
    assign unused_ok = ^{i_req_addr[1:0], d_req_addr[1:0], mem_rvld};

    assign i_in_range = (i_req_addr[31:ADDR_HI] == '0);
    assign d_in_range = (d_req_addr[31:ADDR_HI] == '0);

    // A lone requester always wins; on a tie the round-robin pointer decides.
    assign grant_d   = !RST && d_req_valid && (!i_req_valid || rr == PORT_D);
    assign grant_i   = !RST && i_req_valid && (!d_req_valid || rr == PORT_I);
    assign any_grant = grant_i || grant_d;

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    // Out-of-range requests are still accepted but never reach the memory.
    assign mem_en    = grant_d ? d_in_range : (grant_i && i_in_range);
    assign mem_addr  = grant_d ? d_req_addr[ADDR_HI-1:2]
                     : grant_i ? i_req_addr[ADDR_HI-1:2] : '0;
    assign mem_wen   = grant_d ? d_req_wstrb : '0;
    assign mem_wdata = RST ? '0 : d_req_wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rr          <= PORT_D;
            trk_owner   <= PORT_D;
            trk_is_read <= 1'b0;
            trk_err     <= 1'b0;
            trk_flushed <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                rr <= PORT_I;
            end else if (grant_i) begin
                rr <= PORT_D;
            end
            trk_owner   <= grant_d ? PORT_D : PORT_I;
            trk_is_read <= grant_d ? (d_req_wstrb == '0) : 1'b1;
            trk_err     <= grant_d ? !d_in_range : !i_in_range;
            // Remembers that the fetch accepted alongside a flush is stale.
            trk_flushed <= grant_i && i_flush;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = any_grant ? RESP : IDLE;
            RESP:    state_next = any_grant ? RESP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign pend       = (state == RESP);
    assign i_suppress = trk_flushed || i_flush;
    assign rsp_rdata  = (trk_is_read && !trk_err) ? mem_rdata : '0;

    // RST also masks responses so an in-flight one is dropped immediately.
    assign i_rsp_valid = !RST && pend && (trk_owner == PORT_I) && !i_suppress;
    assign d_rsp_valid = !RST && pend && (trk_owner == PORT_D);
    assign i_rsp_rdata = i_rsp_valid ? rsp_rdata : '0;
    assign d_rsp_rdata = d_rsp_valid ? rsp_rdata : '0;
    assign i_rsp_err   = i_rsp_valid && trk_err;
    assign d_rsp_err   = d_rsp_valid && trk_err;

    // The memory's own read-valid must agree with what the tracker expects.
    mem_rvld_consistent: assert property (
        @(posedge CLK) disable iff (RST) mem_rvld == (pend && trk_is_read && !trk_err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural memory

module tb_mem_port_arbiter;

    logic        CLK;
    logic        RST;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_flush;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic        i_rsp_err;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wen;
    logic [31:0] mem_rdata;
    logic        mem_rvld;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t iq[$];
    rsp_t dq[$];
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
        .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
        .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] pat(int k);
        if (k == 4) return 32'hDEADBEEF;
        if (k == 8) return 32'hAAAAAAAA;
        return 32'hC0DE0000 | k;
    endfunction

    // Memory model: reset (RSTN = ~RST) reloads contents and clears read-valid.
    logic [31:0] mem [0:1023];
    logic        mem_rstn;
    assign mem_rstn = ~RST;

    always @(posedge CLK) begin
        if (!mem_rstn) begin
            for (int k = 0; k < 1024; k++) mem[k] <= pat(k);
            mem_rvld  <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            mem_rvld <= mem_en && (mem_wen == 4'b0);
            if (mem_en) begin
                if (mem_wen == 4'b0) mem_rdata <= mem[mem_addr];
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever a port presents one.
    always @(negedge CLK) begin
        rsp_t e;
        if (i_rsp_valid) begin
            if (iq.size() == 0) begin
                chk("i_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = iq.pop_front();
                chk("i_rsp_rdata", i_rsp_rdata, e.data);
                chk("i_rsp_err", {31'b0, i_rsp_err}, {31'b0, e.err});
            end
        end
        if (d_rsp_valid) begin
            if (dq.size() == 0) begin
                chk("d_rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = dq.pop_front();
                chk("d_rsp_rdata", d_rsp_rdata, e.data);
                chk("d_rsp_err", {31'b0, d_rsp_err}, {31'b0, e.err});
            end
        end
    end

    // One cycle of stimulus: drive just after the edge, return mid-cycle for checks.
    task automatic step(input logic rst, input logic iv, input logic [31:0] ia,
                        input logic dv, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [3:0] dws, input logic fl);
        @(posedge CLK);
        #1;
        RST = rst; i_req_valid = iv; i_req_addr = ia; d_req_valid = dv;
        d_req_addr = da; d_req_wdata = dwd; d_req_wstrb = dws; i_flush = fl;
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic push_i(input logic [31:0] d, input logic e);
        rsp_t r;
        r.data = d; r.err = e;
        iq.push_back(r);
    endtask

    task automatic push_d(input logic [31:0] d, input logic e);
        rsp_t r;
        r.data = d; r.err = e;
        dq.push_back(r);
    endtask

    initial begin
        RST = 1'b1; i_req_valid = 1'b0; i_req_addr = 32'h0; i_flush = 1'b0;
        d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0; d_req_wstrb = 4'h0;

        // Reset with both requesters active: nothing may be accepted.
        for (int n = 0; n < 3; n++)
            step(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 32'h55555555, 4'h0, 1'b0);
        chk("rst_i_req_ready", {31'b0, i_req_ready}, 32'd0);
        chk("rst_d_req_ready", {31'b0, d_req_ready}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rsp_valid", {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);

        for (int n = 0; n < 4; n++) idle();
        chk("idle_mem_en", {31'b0, mem_en}, 32'd0);

        // Ties after reset: D, I, D, I.
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 32'h0, 4'h0, 1'b0);
        chk("tie1_ready", {30'b0, i_req_ready, d_req_ready}, 32'd1);
        chk("tie1_mem_addr", {22'b0, mem_addr}, 32'd32);
        push_d(pat(32), 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h84, 32'h0, 4'h0, 1'b0);
        chk("tie2_ready", {30'b0, i_req_ready, d_req_ready}, 32'd2);
        chk("tie2_mem_addr", {22'b0, mem_addr}, 32'd16);
        push_i(pat(16), 1'b0);
        step(1'b0, 1'b1, 32'h44, 1'b1, 32'h84, 32'h0, 4'h0, 1'b0);
        chk("tie3_ready", {30'b0, i_req_ready, d_req_ready}, 32'd1);
        push_d(pat(33), 1'b0);
        step(1'b0, 1'b1, 32'h44, 1'b1, 32'h88, 32'h0, 4'h0, 1'b0);
        chk("tie4_ready", {30'b0, i_req_ready, d_req_ready}, 32'd2);
        push_i(pat(17), 1'b0);
        idle();

        // Single fetch of word 4.
        step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("fetch_ready", {30'b0, i_req_ready, d_req_ready}, 32'd2);
        chk("fetch_mem_en", {31'b0, mem_en}, 32'd1);
        chk("fetch_mem_addr", {22'b0, mem_addr}, 32'd4);
        push_i(32'hDEADBEEF, 1'b0);
        idle();

        // Partial store then load back.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0);
        chk("store_ready", {31'b0, d_req_ready}, 32'd1);
        chk("store_mem_wen", {28'b0, mem_wen}, 32'd5);
        chk("store_mem_wdata", mem_wdata, 32'h11223344);
        push_d(32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
        chk("load_mem_wen", {28'b0, mem_wen}, 32'd0);
        push_d(32'hAA22AA44, 1'b0);

        // Out-of-range load.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 32'h0, 4'h0, 1'b0);
        chk("oor_ready", {31'b0, d_req_ready}, 32'd1);
        chk("oor_mem_en", {31'b0, mem_en}, 32'd0);
        push_d(32'h0, 1'b1);
        idle();

        // Flush: the next-cycle flush kills an in-flight fetch, D unaffected.
        step(1'b0, 1'b1, 32'h0C, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("fl_fetch_ready", {31'b0, i_req_ready}, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 32'h0, 4'h0, 1'b1);
        chk("fl_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
        chk("fl_d_ready", {31'b0, d_req_ready}, 32'd1);
        push_d(pat(9), 1'b0);
        // Fetch accepted alongside a flush is issued but its response is dropped.
        step(1'b0, 1'b1, 32'h08, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("fl_same_ready", {31'b0, i_req_ready}, 32'd1);
        chk("fl_same_mem_en", {31'b0, mem_en}, 32'd1);
        step(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("fl_after_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
        chk("fl_after_ready", {31'b0, i_req_ready}, 32'd1);
        push_i(pat(5), 1'b0);
        idle();

        // Reset right after a load is accepted drops its response.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h28, 32'h0, 4'h0, 1'b0);
        chk("rl_ready", {31'b0, d_req_ready}, 32'd1);
        step(1'b1, 1'b1, 32'h30, 1'b1, 32'h34, 32'h12345678, 4'h0, 1'b0);
        chk("rl_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
        chk("rl_ready_during", {30'b0, i_req_ready, d_req_ready}, 32'd0);
        chk("rl_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rl_mem_wdata", mem_wdata, 32'h0);
        idle();
        chk("rl_after_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);
        chk("rl_after_mem_en", {31'b0, mem_en}, 32'd0);
        step(1'b0, 1'b1, 32'h34, 1'b1, 32'h30, 32'h0, 4'h0, 1'b0);
        chk("rl_tie_ready", {30'b0, i_req_ready, d_req_ready}, 32'd1);
        push_d(pat(12), 1'b0);
        for (int n = 0; n < 3; n++) idle();

        chk("iq_drained", iq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
